// File: rtl/instr_queue.sv
// instr_queue: issue-side receiver for the fetch->issue pipeline register.
// A circular FIFO of fetched bundles that presents them in order to dispatch.
// It raises stall when full and is emptied by the pipeline flush.
// Optional macro IQ_BYPASS_EN: an empty queue forwards an incoming bundle
// combinationally to dispatch in the same cycle.
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       stall,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    occ;
  logic             empty;
  logic             enq;
  logic             deq;

  assign empty = (occ == '0);
  assign stall = (occ == CW'(DEPTH));
  assign count = occ;

`ifdef IQ_BYPASS_EN
  logic bypass;

  // An empty queue hands a valid incoming bundle straight to dispatch; it is
  // only written into storage when dispatch does not take it this cycle.
  always_comb begin
    bypass    = empty && in_valid && !flush;
    out_valid = !empty || bypass;
    out_data  = bypass ? in_data : mem[head];
    enq       = in_valid && !stall && !flush && !(bypass && out_ready);
    deq       = !empty && out_ready && !flush;
  end
`else
  // Outputs come from registered state only, so a new bundle is visible one
  // cycle after it is written; flush suppresses both enqueue and dequeue.
  always_comb begin
    out_valid = !empty;
    out_data  = mem[head];
    enq       = in_valid && !stall && !flush;
    deq       = out_valid && out_ready && !flush;
  end
`endif

  // Storage is intentionally not reset; only the pointers define valid entries.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[tail] <= in_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (enq) begin
        tail <= tail + AW'(1);
      end
      if (deq) begin
        head <= head + AW'(1);
      end
      case ({enq, deq})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: scoreboard bench for instr_queue (DEPTH=8, WIDTH=64).
// Expected bundles are queued when driven and accepted, then popped as
// dispatch consumes them. Honours IQ_BYPASS_EN when it is defined.
module tb_instr_queue;

  localparam int DEPTH = 8;
  localparam int WIDTH = 64;

  logic             clk;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             stall;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [3:0]       count;

  logic [WIDTH-1:0] exp_q [$];
  int               model_count;
  int               num_compared;
  int               num_mismatched;

  instr_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .stall     (stall),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] expv);
    num_compared++;
    if (act !== expv) begin
      num_mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", tag, act, expv, $time);
    end
  endtask

  // Drive one cycle: inputs applied after the previous edge, outputs checked at
  // the falling edge, then the model advances at the rising edge.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                               input logic r, input logic f);
    logic             byp;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic             m_enq;
    logic             m_deq;
    logic             is_full;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    is_full   = (model_count == DEPTH);
`ifdef IQ_BYPASS_EN
    byp = (model_count == 0) && v && !f;
`else
    byp = 1'b0;
`endif
    exp_valid = (model_count != 0) || byp;
    exp_data  = byp ? d : ((exp_q.size() != 0) ? exp_q[0] : '0);
    m_enq     = v && !is_full && !f && !(byp && r);
    m_deq     = (model_count != 0) && r && !f;
    @(negedge clk);
    checkOutput("count", WIDTH'(count), WIDTH'(model_count));
    checkOutput("stall", WIDTH'(stall), WIDTH'(is_full));
    checkOutput("out_valid", WIDTH'(out_valid), WIDTH'(exp_valid));
    if (exp_valid) begin
      checkOutput("out_data", out_data, exp_data);
    end
    @(posedge clk);
    if (f) begin
      exp_q.delete();
    end else begin
      if (m_deq) void'(exp_q.pop_front());
      if (m_enq) exp_q.push_back(d);
    end
    model_count = exp_q.size();
    #1;
  endtask

  initial begin
    num_compared   = 0;
    num_mismatched = 0;
    model_count    = 0;
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    #12;
    checkOutput("reset_count", WIDTH'(count), '0);
    checkOutput("reset_stall", WIDTH'(stall), '0);
    checkOutput("reset_out_valid", WIDTH'(out_valid), '0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full, then hold a ninth bundle that must not be written
    $display("[TB] fill");
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, WIDTH'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h9, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h9, 1'b0, 1'b0);

    // Drain in order
    $display("[TB] drain");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Occupancy 4, then concurrent enqueue/dequeue across the wrap
    $display("[TB] wrap");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 64'h100 + WIDTH'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 64'h200 + WIDTH'(i), 1'b1, 1'b0);

    // Flush at occupancy 5 with enqueue and dequeue requested
    $display("[TB] flush");
    applyStimulus(1'b1, 64'h300, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'hDEAD, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h301, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Async reset between clock edges with three entries queued
    $display("[TB] async reset");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 64'h400 + WIDTH'(i), 1'b0, 1'b0);
    checkOutput("pre_reset_count", WIDTH'(count), 64'd3);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_count", WIDTH'(count), '0);
    checkOutput("async_out_valid", WIDTH'(out_valid), '0);
    checkOutput("async_stall", WIDTH'(stall), '0);
    exp_q.delete();
    model_count = 0;
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Bypass (or one-cycle latency without it)
    $display("[TB] bypass");
    applyStimulus(1'b1, 64'hAB, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Randomised traffic with occasional flushes
    $display("[TB] random");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), {32'h0, $urandom()},
                    1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
